imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decodes the RV32I immediate, immediate type and rd of each
// fetched instruction and holds the results in a 2-entry in-order skid buffer.
// It also keeps a saturating count of accepted illegal opcodes.
module imm_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [2:0]  out_imm_type,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  output logic [15:0] illegal_cnt
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned CNT_W  = 16;

  // Immediate-type codes shared with downstream stages
  localparam logic [TYPE_W-1:0] IMM_NONE = 3'd0;
  localparam logic [TYPE_W-1:0] IMM_I    = 3'd1;
  localparam logic [TYPE_W-1:0] IMM_S    = 3'd2;
  localparam logic [TYPE_W-1:0] IMM_B    = 3'd3;
  localparam logic [TYPE_W-1:0] IMM_U    = 3'd4;
  localparam logic [TYPE_W-1:0] IMM_J    = 3'd5;

  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [TYPE_W-1:0] imm_type;
    logic [RD_W-1:0]   rd;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;
  entry_t dec_c;
  entry_t head, tail;
  logic   accept, consume;
  logic   head_ld, head_from_tail, tail_ld;

  // Decode the incoming instruction into a buffer entry
  always_comb begin
    dec_c          = '0;
    dec_c.pc       = in_pc;
    dec_c.rd       = in_inst[11:7];
    dec_c.imm_type = IMM_NONE;
    dec_c.imm      = '0;
    dec_c.illegal  = 1'b0;
    unique case (in_inst[6:0])
      OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec_c.imm_type = IMM_I;
        dec_c.imm      = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        dec_c.imm_type = IMM_S;
        dec_c.imm      = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        dec_c.imm_type = IMM_B;
        dec_c.imm      = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                          in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_c.imm_type = IMM_U;
        dec_c.imm      = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_c.imm_type = IMM_J;
        dec_c.imm      = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                          in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_OP: begin
        dec_c.imm_type = IMM_NONE;
      end
      default: begin
        dec_c.illegal = 1'b1;
      end
    endcase
  end

  // Skid-buffer next state and entry load controls
  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_tail = 1'b0;
    tail_ld        = 1'b0;
    accept         = in_valid && in_ready;
    consume        = out_valid && out_ready;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            head_ld   = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            head_ld = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            tail_ld   = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_nxt      = ONE;
            head_ld        = 1'b1;
            head_from_tail = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // State register; handshake outputs follow the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // Entry storage: head drives the outputs, tail is the skid slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (head_ld) head <= head_from_tail ? tail : dec_c;
      if (tail_ld) tail <= dec_c;
    end
  end

  // Saturating count of accepted illegal instructions (flush does not gate it)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (accept && dec_c.illegal && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign out_pc       = head.pc;
  assign out_imm      = head.imm;
  assign out_imm_type = head.imm_type;
  assign out_rd       = head.rd;
  assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_imm_decode_stage;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_type;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  imm_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_imm_type(out_imm_type),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: queue of held instructions, expected ready and count
  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];
  logic        exp_rdy;
  logic [15:0] exp_cnt;
  bit          quiet;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  ty;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Immediate computed arithmetically from the field weights of each format
  function automatic void ref_decode(input logic [31:0] i, output logic [31:0] imm,
                                     output logic [2:0] ty, output logic ill);
    int v;
    imm = 32'd0;
    ty  = T_NONE;
    ill = 1'b0;
    v   = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin
        ty  = T_I;
        imm = 32'($signed(i) >>> 20);
      end
      7'h23: begin
        ty  = T_S;
        imm = (32'($signed(i) >>> 20) & ~32'h1F) | 32'(i[11:7]);
      end
      7'h63: begin
        ty  = T_B;
        v   = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        imm = 32'(v);
      end
      7'h37, 7'h17: begin
        ty  = T_U;
        imm = i & 32'hFFFFF000;
      end
      7'h6F: begin
        ty  = T_J;
        v   = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
              + int'(i[30:21]) * 2;
        imm = 32'(v);
      end
      7'h33: ty = T_NONE;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] imm;
    logic [2:0]  ty;
    logic        ill;
    if (quiet) return;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q_inst.size() != 0));
    chk({tag, ".illegal_cnt"}, 32'(illegal_cnt), 32'(exp_cnt));
    if (q_inst.size() != 0) begin
      ref_decode(q_inst[0], imm, ty, ill);
      chk({tag, ".out_pc"}, out_pc, q_pc[0]);
      chk({tag, ".out_imm"}, out_imm, imm);
      chk({tag, ".out_imm_type"}, 32'(out_imm_type), 32'(ty));
      chk({tag, ".out_rd"}, 32'(out_rd), 32'(q_inst[0][11:7]));
      chk({tag, ".out_illegal"}, 32'(out_illegal), 32'(ill));
    end
  endtask

  // Drive one cycle right after a falling edge, advance the model, check at next falling edge
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl, input string tag);
    logic        acc, cons;
    logic [31:0] imm;
    logic [2:0]  ty;
    logic        ill;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc  = v && exp_rdy;
    cons = (q_inst.size() != 0) && ordy;
    ref_decode(inst, imm, ty, ill);
    if (acc && ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    if (fl) begin
      q_inst.delete();
      q_pc.delete();
    end else begin
      if (cons) begin
        void'(q_inst.pop_front());
        void'(q_pc.pop_front());
      end
      if (acc) begin
        q_inst.push_back(inst);
        q_pc.push_back(pc);
      end
    end
    exp_rdy = (q_inst.size() < 2);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inst   = 32'd0;
    in_pc     = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    q_inst.delete();
    q_pc.delete();
    exp_rdy = 1'b0;
    exp_cnt = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0]  ops[11];
    logic [31:0] r;
    logic [6:0]  op;
    int          k;
    int          guard;

    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};

    tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, T_I,    5'd1,  1'b0}; // addi x1,x0,-1
    tbl[1]  = '{32'hFE112E23, 32'hFFFFFFFC, T_S,    5'd28, 1'b0}; // sw x1,-4(x2)
    tbl[2]  = '{32'h123452B7, 32'h12345000, T_U,    5'd5,  1'b0}; // lui x5,0x12345
    tbl[3]  = '{32'h00000000, 32'h00000000, T_NONE, 5'd0,  1'b1}; // all-zero word
    tbl[4]  = '{32'h00B50533, 32'h00000000, T_NONE, 5'd10, 1'b0}; // add x10,x10,x11
    tbl[5]  = '{32'hFE000EE3, 32'hFFFFFFFC, T_B,    5'd29, 1'b0}; // beq x0,x0,-4
    tbl[6]  = '{32'h002000EF, 32'h00000002, T_J,    5'd1,  1'b0}; // jal x1,+2
    tbl[7]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, T_J,    5'd1,  1'b0}; // jal x1,-4
    tbl[8]  = '{32'h00001197, 32'h00001000, T_U,    5'd3,  1'b0}; // auipc x3,1
    tbl[9]  = '{32'h0080A103, 32'h00000008, T_I,    5'd2,  1'b0}; // lw x2,8(x1)
    tbl[10] = '{32'h00000073, 32'h00000000, T_I,    5'd0,  1'b0}; // ecall
    tbl[11] = '{32'h000080E7, 32'h00000000, T_I,    5'd1,  1'b0}; // jalr x1,0(x1)
    tbl[12] = '{32'hFFFFFFFF, 32'h00000000, T_NONE, 5'd31, 1'b1}; // unknown opcode

    quiet = 1'b0;

    // Reset values while rst is held
    rst = 1'b1;
    in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0; flush = 1'b0; out_ready = 1'b0;
    q_inst.delete(); q_pc.delete();
    exp_rdy = 1'b0; exp_cnt = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.illegal_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst.out_pc", out_pc, 32'd0);
    chk("rst.out_imm", out_imm, 32'd0);
    chk("rst.out_fields", {24'd0, out_imm_type, out_rd}, 32'd0);
    chk("rst.out_illegal", 32'(out_illegal), 32'd0);
    rst = 1'b0;

    // First edge after reset release raises in_ready
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "post_rst");
    chk("post_rst.in_ready_const", 32'(in_ready), 32'd1);

    // Vector table, one instruction per cycle with the consumer always ready
    for (int i = 0; i < 13; i++) begin
      step(1'b1, tbl[i].inst, 32'h1000 + 32'(i * 4), 1'b1, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d.imm", i), out_imm, tbl[i].imm);
      chk($sformatf("vec%0d.type", i), 32'(out_imm_type), 32'(tbl[i].ty));
      chk($sformatf("vec%0d.rd", i), 32'(out_rd), 32'(tbl[i].rd));
      chk($sformatf("vec%0d.illegal", i), 32'(out_illegal), 32'(tbl[i].ill));
    end
    chk("vec.illegal_cnt", 32'(illegal_cnt), 32'd2);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "drain0");

    // Stalled consumer: A and B held, C waits upstream, then A,B,C in order
    step(1'b1, 32'hFFF00093, 32'hA0, 1'b0, 1'b0, "stall.a");
    step(1'b1, 32'hFE112E23, 32'hB0, 1'b0, 1'b0, "stall.b");
    step(1'b1, 32'h123452B7, 32'hC0, 1'b0, 1'b0, "stall.c_wait");
    chk("stall.in_ready_low", 32'(in_ready), 32'd0);
    chk("stall.head_a", out_pc, 32'hA0);
    step(1'b1, 32'h123452B7, 32'hC0, 1'b1, 1'b0, "stall.pop_a");
    chk("stall.head_b", out_pc, 32'hB0);
    step(1'b1, 32'h123452B7, 32'hC0, 1'b1, 1'b0, "stall.pop_b");
    chk("stall.head_c", out_pc, 32'hC0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "stall.pop_c");
    chk("stall.empty", 32'(out_valid), 32'd0);

    // Flush in TWO with a new offer: everything dropped, ready next cycle
    step(1'b1, 32'h00B50533, 32'h200, 1'b0, 1'b0, "flush2.a");
    step(1'b1, 32'h0080A103, 32'h204, 1'b0, 1'b0, "flush2.b");
    step(1'b1, 32'h00001197, 32'h208, 1'b1, 1'b1, "flush2.f");
    chk("flush2.out_valid", 32'(out_valid), 32'd0);
    chk("flush2.in_ready", 32'(in_ready), 32'd1);

    // Flush in ONE while an illegal word is accepted: still counted
    step(1'b1, 32'h00B50533, 32'h300, 1'b0, 1'b0, "flush1.a");
    step(1'b1, 32'h00000000, 32'h304, 1'b0, 1'b1, "flush1.f");
    chk("flush1.out_valid", 32'(out_valid), 32'd0);
    chk("flush1.illegal_cnt", 32'(illegal_cnt), 32'd3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom;
      k  = $urandom_range(0, 11);
      op = (k == 11) ? 7'($urandom) : ops[k];
      step(($urandom % 4) != 0, {r[31:7], op}, $urandom, ($urandom % 3) != 0,
           ($urandom % 32) == 0, "rand");
    end

    // Saturation: fill the counter to 0xFFFF, then one more illegal
    do_reset();
    quiet = 1'b1;
    guard = 0;
    while (exp_cnt != 16'hFFFF && guard < 70000) begin
      step(1'b1, 32'h00000000, 32'h400, 1'b1, 1'b0, "sat.fill");
      guard++;
    end
    quiet = 1'b0;
    check_all("sat.full");
    chk("sat.full_const", 32'(illegal_cnt), 32'h0000FFFF);
    step(1'b1, 32'h00000000, 32'h404, 1'b1, 1'b0, "sat.more");
    chk("sat.more_const", 32'(illegal_cnt), 32'h0000FFFF);
    chk("sat.more_illegal", 32'(out_illegal), 32'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "sat.drain");

    // Asynchronous reset pulse between edges while in TWO
    step(1'b1, 32'h00000000, 32'h500, 1'b0, 1'b0, "arst.a");
    step(1'b1, 32'hFFF00093, 32'h504, 1'b0, 1'b0, "arst.b");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q_inst.delete(); q_pc.delete();
    exp_rdy = 1'b0; exp_cnt = 16'd0;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.illegal_cnt", 32'(illegal_cnt), 32'd0);
    chk("arst.out_pc", out_pc, 32'd0);
    check_all("arst");
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_rdy = 1'b1;
    check_all("arst.after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
